// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-control field positions and a
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_STICK  = 5;
  localparam int LCR_BRK    = 6;

  // Parity over the active word length only; stick parity ignores the data.
  function automatic logic frame_parity(input logic [7:0] data, input logic [5:0] fmt);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - fmt[LCR_WLS_HI:LCR_WLS_LO]);
    if (fmt[LCR_STICK]) begin
      return ~fmt[LCR_EPS];
    end
    return fmt[LCR_EPS] ? ^(data & mask) : ~^(data & mask);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data, registered flags and occupancy.
// A push is accepted when not full, or when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic [AW:0]       level_d;
  logic              full_q;
  logic              empty_q;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_ok = pop_i && !empty_q;
  assign wr_ok = push_i && (!full_q || rd_ok);

  always_comb begin
    level_d = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == DEPTH_V);
      empty_q <= (level_d == '0);
    end
  end

  // Storage kept out of the reset domain so it maps onto block RAM; a write and
  // read of the same slot in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
    if (rd_ok) rdata_q <= mem_q[rd_ptr_q];
  end

  assign rdata_o = rdata_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; frame format is captured per frame
// from lcr, while the break bit acts live on the line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bclk,
  input  logic [7:0]  din,
  input  logic        wr_en,
  input  logic [7:0]  lcr,
  output logic        tx,
  output logic        full,
  output logic        thre,
  output logic        temt,
  output logic        overrun,
  output logic [AW:0] level
);

  localparam int TW = $clog2(2*OSR) + 1;
  localparam logic [TW-1:0] BIT_LAST    = TW'(OSR - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(OSR + OSR/2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2*OSR - 1);

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [5:0]    fmt_q, fmt_d;
  logic          par_q, par_d;
  logic          tx_q;
  logic          overrun_q;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          line;
  logic          tick_last;
  logic [TW-1:0] stop_last;
  logic [2:0]    bit_last;
  logic          lcr_unused;

  assign lcr_unused = lcr[7];
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

  uart_sync_fifo #(
    .DATA_W    (8),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AW        (AW)
  ) u_fifo (
    .clk    (clk),
    .rst_ni (reset),
    .push_i (wr_en),
    .pop_i  (fifo_pop),
    .wdata_i(din),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(level)
  );

  assign tick_last = (tick_q == BIT_LAST);
  assign bit_last  = 3'd4 + {1'b0, fmt_q[LCR_WLS_HI:LCR_WLS_LO]};

  // 1.5 stop bits only exist for 5-bit words; other STB formats use two.
  always_comb begin
    stop_last = BIT_LAST;
    if (fmt_q[LCR_STB]) begin
      stop_last = (fmt_q[LCR_WLS_HI:LCR_WLS_LO] == 2'd0) ? STOP15_LAST : STOP2_LAST;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fmt_d   = fmt_q;
    par_d   = par_q;
    line    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_rdata;
        fmt_d   = lcr[5:0];
        par_d   = frame_parity(fifo_rdata, lcr[5:0]);
        tick_d  = '0;
        bit_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        line = 1'b0;
        if (bclk) begin
          tick_d = tick_last ? '0 : tick_q + 1'b1;
          if (tick_last) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        line = shift_q[0];
        if (bclk) begin
          tick_d = tick_last ? '0 : tick_q + 1'b1;
          if (tick_last) begin
            shift_d = shift_q >> 1;
            if (bit_q == bit_last) begin
              bit_d   = '0;
              state_d = fmt_q[LCR_PEN] ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      ST_PARITY: begin
        line = par_q;
        if (bclk) begin
          tick_d = tick_last ? '0 : tick_q + 1'b1;
          if (tick_last) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        line = 1'b1;
        if (bclk) begin
          if (tick_q == stop_last) begin
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      fmt_q     <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      fmt_q     <= fmt_d;
      par_q     <= par_d;
      tx_q      <= lcr[LCR_BRK] ? 1'b0 : line;
      overrun_q <= wr_en && fifo_full && !fifo_pop;
    end
  end

  assign tx      = tx_q;
  assign full    = fifo_full;
  assign thre    = fifo_empty;
  assign temt    = fifo_empty && (state_q == ST_IDLE);
  assign overrun = overrun_q;

endmodule
